// File: rtl/arbiter_n_to_1_request.sv
// Round-robin arbiter merging N requester packet streams onto one registered request channel.
// Each packet is {valid, payload}; grants are held for bounded bursts, and fifo_stall_in blocks acceptance.
module arbiter_n_to_1_request #(
  parameter int NUM_MEMORY_REQUESTOR = 2,
  parameter int DATA_WIDTH           = 32,
  parameter int MAX_GRANT_BURST      = 4,
  parameter int ID_BITS              = $clog2(NUM_MEMORY_REQUESTOR)
) (
  input  logic                                            ap_clk,
  input  logic                                            ap_rst_n,
  input  logic [NUM_MEMORY_REQUESTOR-1:0][DATA_WIDTH:0]   request_in,
  output logic [NUM_MEMORY_REQUESTOR-1:0]                 request_in_ready,
  output logic [DATA_WIDTH:0]                             request_out,
  output logic [ID_BITS-1:0]                              request_out_id,
  input  logic                                            fifo_stall_in,
  output logic                                            grant_busy
);

  localparam int N        = NUM_MEMORY_REQUESTOR;
  localparam int CNT_BITS = $clog2(MAX_GRANT_BURST + 1);
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(MAX_GRANT_BURST - 1);
  localparam logic [ID_BITS-1:0]  ID_LAST  = ID_BITS'(N - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                state, state_d;
  logic [ID_BITS-1:0]    grant_idx, grant_idx_d;
  logic [ID_BITS-1:0]    last_grant, last_grant_d;
  logic [ID_BITS-1:0]    rr_pick;
  logic [CNT_BITS-1:0]   burst_cnt, burst_cnt_d;
  logic [N-1:0]          valid;
  logic [N-1:0]          grant_onehot;
  logic                  any_valid;
  logic                  others_valid;
  logic                  grant_valid;
  logic                  transfer;

  always_comb begin
    for (int i = 0; i < N; i++) valid[i] = request_in[i][DATA_WIDTH];
  end

  always_comb begin
    grant_onehot            = '0;
    grant_onehot[grant_idx] = 1'b1;
  end

  assign any_valid    = |valid;
  assign grant_valid  = valid[grant_idx];
  assign others_valid = |(valid & ~grant_onehot);
  assign grant_busy   = (state == BURST);

  // Scan from the largest offset down so the nearest requester after last_grant wins.
  always_comb begin
    int cand;
    cand    = 0;
    rr_pick = last_grant;
    for (int off = N; off >= 1; off--) begin
      cand = int'(last_grant) + off;
      if (cand >= N) cand = cand - N;
      if (valid[ID_BITS'(cand)]) rr_pick = ID_BITS'(cand);
    end
  end

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d          = state;
    grant_idx_d      = grant_idx;
    last_grant_d     = last_grant;
    burst_cnt_d      = burst_cnt;
    request_in_ready = '0;
    transfer         = 1'b0;
    case (state)
      IDLE: begin
        if (any_valid && !fifo_stall_in) begin
          grant_idx_d = rr_pick;
          burst_cnt_d = '0;
          state_d     = BURST;
        end
      end
      BURST: begin
        transfer         = grant_valid && !fifo_stall_in;
        request_in_ready = transfer ? grant_onehot : '0;
        if (!grant_valid) begin
          state_d      = IDLE;
          last_grant_d = grant_idx;
        end else if (transfer) begin
          // At the burst limit the count saturates; the grant is only given up if someone waits.
          if (burst_cnt != CNT_LAST) begin
            burst_cnt_d = burst_cnt + 1'b1;
          end else if (others_valid) begin
            state_d      = IDLE;
            last_grant_d = grant_idx;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state      <= IDLE;
      grant_idx  <= '0;
      last_grant <= ID_LAST;
      burst_cnt  <= '0;
    end else begin
      state      <= state_d;
      grant_idx  <= grant_idx_d;
      last_grant <= last_grant_d;
      burst_cnt  <= burst_cnt_d;
    end
  end

  // Payload and id hold their last value on cycles without a transfer.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      request_out    <= '0;
      request_out_id <= '0;
    end else begin
      request_out[DATA_WIDTH] <= transfer;
      if (transfer) begin
        request_out[DATA_WIDTH-1:0] <= request_in[grant_idx][DATA_WIDTH-1:0];
        request_out_id              <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_arbiter_n_to_1_request.sv
// Self-checking bench for arbiter_n_to_1_request: directed vector table on N=2/MAX=4,
// directed rotation on N=4/MAX=2, and randomized traffic against a transaction-level model.
module tb_arbiter_n_to_1_request;

  localparam int DW   = 32;
  localparam int MAX2 = 4;
  localparam int MAX4 = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0][DW:0] req2;
  logic [1:0]       rdy2;
  logic [DW:0]      out2;
  logic [0:0]       id2;
  logic             stall2;
  logic             busy2;

  logic [3:0][DW:0] req4;
  logic [3:0]       rdy4;
  logic [DW:0]      out4;
  logic [1:0]       id4;
  logic             stall4;
  logic             busy4;

  arbiter_n_to_1_request #(
    .NUM_MEMORY_REQUESTOR(2), .DATA_WIDTH(DW), .MAX_GRANT_BURST(MAX2), .ID_BITS(1)
  ) dut2 (
    .ap_clk(clk), .ap_rst_n(rst_n), .request_in(req2), .request_in_ready(rdy2),
    .request_out(out2), .request_out_id(id2), .fifo_stall_in(stall2), .grant_busy(busy2)
  );

  arbiter_n_to_1_request #(
    .NUM_MEMORY_REQUESTOR(4), .DATA_WIDTH(DW), .MAX_GRANT_BURST(MAX4), .ID_BITS(2)
  ) dut4 (
    .ap_clk(clk), .ap_rst_n(rst_n), .request_in(req4), .request_in_ready(rdy4),
    .request_out(out4), .request_out_id(id4), .fifo_stall_in(stall4), .grant_busy(busy4)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int i, input int unsigned c);
    return (DW'(i) << 24) | DW'(c & 32'h00FF_FFFF);
  endfunction

  typedef struct {
    logic [1:0] v;
    logic       st;
    logic [1:0] rdy;
    logic       busy;
    logic       ov;
    logic [0:0] oid;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [1:0] v, input logic st, input logic [1:0] rdy,
                     input logic busy, input logic ov, input logic [0:0] oid);
    vec_t r;
    r.v = v; r.st = st; r.rdy = rdy; r.busy = busy; r.ov = ov; r.oid = oid;
    tbl.push_back(r);
  endtask

  int unsigned pc2[2];
  int unsigned pc4[4];

  // Random-phase model state: owner = requester holding the grant (-1 when none).
  logic [3:0]    v4;
  int            owner, run, last, acc;
  logic [3:0]    exp_rdy4;
  logic          exp_ov4;
  int            exp_id4;
  logic [DW-1:0] exp_pl4;

  logic [3:0] seq_v   [10] = '{4'b0010, 4'b0010, 4'b0000, 4'b1010, 4'b1010,
                               4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1010};
  logic [3:0] seq_rdy [10] = '{4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b1000,
                               4'b1000, 4'b0000, 4'b0010, 4'b0010, 4'b0000};
  logic       seq_ov  [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  int         seq_id  [10] = '{0, 1, 0, 0, 3, 3, 0, 1, 1, 0};

  initial begin
    logic [DW-1:0] exp_pl;
    logic          exp_acc;

    // Two saturated requesters, then a 3-cycle stall mid-burst of requester 0,
    // then requester 0 dropping valid after two packets.
    add(2'b11, 0, 2'b00, 0, 0, 0);
    for (int k = 0; k < 4; k++) add(2'b11, 0, 2'b01, 1, 1, 0);
    add(2'b11, 0, 2'b00, 0, 0, 0);
    for (int k = 0; k < 4; k++) add(2'b11, 0, 2'b10, 1, 1, 1);
    add(2'b11, 0, 2'b00, 0, 0, 0);
    add(2'b11, 0, 2'b01, 1, 1, 0);
    for (int k = 0; k < 3; k++) add(2'b11, 1, 2'b00, 1, 0, 0);
    for (int k = 0; k < 3; k++) add(2'b11, 0, 2'b01, 1, 1, 0);
    add(2'b00, 0, 2'b00, 0, 0, 0);
    add(2'b01, 0, 2'b00, 0, 0, 0);
    add(2'b11, 0, 2'b01, 1, 1, 0);
    add(2'b11, 0, 2'b01, 1, 1, 0);
    add(2'b10, 0, 2'b00, 1, 0, 0);
    add(2'b11, 0, 2'b00, 0, 0, 0);
    add(2'b11, 0, 2'b10, 1, 1, 1);
    add(2'b00, 0, 2'b00, 1, 0, 0);
    add(2'b00, 0, 2'b00, 0, 0, 0);

    // Reset held with every requester valid.
    rst_n  = 1'b0;
    stall2 = 1'b0;
    stall4 = 1'b0;
    for (int i = 0; i < 2; i++) req2[i] = {1'b1, mk(i, 0)};
    for (int i = 0; i < 4; i++) req4[i] = {1'b1, mk(i, 0)};
    repeat (3) @(negedge clk);
    check("rst_rdy2", rdy2, 0);
    check("rst_out2", out2, 0);
    check("rst_busy2", busy2, 0);
    check("rst_id2", id2, 0);
    check("rst_rdy4", rdy4, 0);
    check("rst_busy4", busy4, 0);
    req2 = '0;
    req4 = '0;
    rst_n = 1'b1;

    // Table-driven phase on the N=2 instance.
    foreach (tbl[k]) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) req2[i] = {tbl[k].v[i], mk(i, pc2[i])};
      stall2 = tbl[k].st;
      #1;
      check($sformatf("tbl[%0d] ready", k), rdy2, tbl[k].rdy);
      check($sformatf("tbl[%0d] busy", k), busy2, tbl[k].busy);
      exp_pl = '0;
      for (int i = 0; i < 2; i++) begin
        if (tbl[k].rdy[i]) begin
          exp_pl = mk(i, pc2[i]);
          pc2[i]++;
        end
      end
      @(posedge clk);
      #1;
      check($sformatf("tbl[%0d] out_valid", k), out2[DW], tbl[k].ov);
      if (tbl[k].ov) begin
        check($sformatf("tbl[%0d] out_id", k), id2, tbl[k].oid);
        check($sformatf("tbl[%0d] payload", k), out2[DW-1:0], exp_pl);
      end
    end

    // Requester 1 alone for 10 packets: one bubble, then back-to-back with no re-arbitration.
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      req2[0] = '0;
      req2[1] = {1'b1, mk(1, pc2[1])};
      stall2  = 1'b0;
      exp_acc = (k != 0);
      exp_pl  = mk(1, pc2[1]);
      #1;
      check($sformatf("solo[%0d] ready", k), rdy2, exp_acc ? 2'b10 : 2'b00);
      if (exp_acc) pc2[1]++;
      @(posedge clk);
      #1;
      check($sformatf("solo[%0d] out_valid", k), out2[DW], exp_acc);
      if (exp_acc) begin
        check($sformatf("solo[%0d] out_id", k), id2, 1);
        check($sformatf("solo[%0d] payload", k), out2[DW-1:0], exp_pl);
      end
    end
    check("solo burst_cnt saturated", dut2.burst_cnt, MAX2 - 1);
    @(negedge clk);
    req2 = '0;

    // N=4: from last_grant=1 with requesters 1 and 3 valid, grant alternates 3,1 skipping 0 and 2.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) req4[i] = {seq_v[k][i], mk(i, pc4[i])};
      stall4 = 1'b0;
      #1;
      check($sformatf("rot[%0d] ready", k), rdy4, seq_rdy[k]);
      for (int i = 0; i < 4; i++) if (seq_rdy[k][i]) pc4[i]++;
      @(posedge clk);
      #1;
      check($sformatf("rot[%0d] out_valid", k), out4[DW], seq_ov[k]);
      if (seq_ov[k]) check($sformatf("rot[%0d] out_id", k), id4, seq_id[k]);
    end

    // Fresh reset, then randomized traffic on N=4 against the model.
    @(negedge clk);
    rst_n = 1'b0;
    req4  = '0;
    req2  = '0;
    v4    = '0;
    @(negedge clk);
    rst_n   = 1'b1;
    owner   = -1;
    run     = 0;
    last    = 3;
    exp_ov4 = 1'b0;
    exp_id4 = 0;
    exp_pl4 = '0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      check($sformatf("rnd[%0d] out_valid", k), out4[DW], exp_ov4);
      if (exp_ov4) begin
        check($sformatf("rnd[%0d] out_id", k), id4, exp_id4);
        check($sformatf("rnd[%0d] payload", k), out4[DW-1:0], exp_pl4);
      end
      for (int i = 0; i < 4; i++) if (!v4[i] && $urandom_range(0, 99) < 40) v4[i] = 1'b1;
      stall4 = ($urandom_range(0, 99) < 20);
      for (int i = 0; i < 4; i++) req4[i] = {v4[i], mk(i, pc4[i])};
      #1;
      exp_rdy4 = '0;
      exp_ov4  = 1'b0;
      acc      = -1;
      check($sformatf("rnd[%0d] busy", k), busy4, owner >= 0);
      if (owner < 0) begin
        if (v4 != 0 && !stall4) begin
          for (int d = 4; d >= 1; d--) if (v4[(last + d) % 4]) owner = (last + d) % 4;
          run = 0;
        end
      end else if (!v4[owner]) begin
        last  = owner;
        owner = -1;
      end else if (!stall4) begin
        exp_rdy4[owner] = 1'b1;
        exp_ov4         = 1'b1;
        exp_id4         = owner;
        exp_pl4         = mk(owner, pc4[owner]);
        acc             = owner;
        run++;
        if (run >= MAX4 && (v4 & ~(4'b0001 << owner)) != 0) begin
          last  = owner;
          owner = -1;
        end
      end
      check($sformatf("rnd[%0d] ready", k), rdy4, exp_rdy4);
      if (acc >= 0) begin
        pc4[acc]++;
        v4[acc] = ($urandom_range(0, 99) < 70);
      end
    end

    // Reset asserted mid-burst clears outputs immediately.
    @(negedge clk);
    req4 = '0;
    req2[0] = {1'b1, mk(0, pc2[0])};
    req2[1] = '0;
    repeat (3) @(negedge clk);
    #1;
    check("midrst busy before", busy2, 1);
    rst_n = 1'b0;
    #1;
    check("midrst ready", rdy2, 0);
    check("midrst out", out2, 0);
    check("midrst id", id2, 0);
    check("midrst busy", busy2, 0);
    @(negedge clk);
    req2  = '0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/arbiter_n_to_1_request.md
# arbiter_N_to_1_request

Round-robin arbiter that merges N requester MemoryPacket streams onto one shared memory-request channel. It is the inverse of the 1-to-N request demux: engines/lanes feed it, and its output drives the downstream request FIFO. Grants are held for bounded bursts to preserve locality. Downstream prog_full backpressure stalls the accepting requester without dropping packets.

## Interface
- NUM_MEMORY_REQUESTOR, 2, number of requesters N (≥2)
- DATA_WIDTH, $bits(MemoryPacketPayload), payload width
- MAX_GRANT_BURST, 4, max consecutive transfers per grant while others wait (≥1)
- ID_BITS, $clog2(NUM_MEMORY_REQUESTOR), width of source index
- ap_clk  in  1  clock; all logic on rising edge
- ap_rst_n  in  1  reset; asynchronous, active-low
- request_in  in  N×MemoryPacket  per-requester valid + payload
- request_in_ready  out  N  accept strobe; at most one bit high per cycle
- request_out  out  MemoryPacket  registered merged output (valid + payload)
- request_out_id  out  ID_BITS  index of requester that sourced request_out
- fifo_stall_in  in  1  downstream prog_full; no acceptance while high
- grant_busy  out  1  high while in BURST state

## Operation
- FSM states: IDLE, BURST. Registers: grant_idx (ID_BITS), last_grant (ID_BITS), burst_cnt ($clog2(MAX_GRANT_BURST+1)).
- Reset (async assert, sync release via ap_clk): state=IDLE, last_grant=N-1, grant_idx=0, burst_cnt=0, request_out.valid=0, request_out.payload=0, request_out_id=0, request_in_ready=0, grant_busy=0.
- IDLE: request_in_ready=0. If any request_in[i].valid and fifo_stall_in=0: grant_idx ← first valid index scanning last_grant+1, +2, … modulo N; burst_cnt ← 0; → BURST. Otherwise stay.
- BURST: transfer = request_in[grant_idx].valid & ~fifo_stall_in; request_in_ready[grant_idx] = transfer (combinational), all other bits 0.
- On transfer: burst_cnt ← burst_cnt+1; output register captures payload and grant_idx.
- Leave BURST → IDLE, last_grant ← grant_idx, when either:
  - request_in[grant_idx].valid=0 (checked regardless of stall), or
  - transfer and burst_cnt==MAX_GRANT_BURST-1 and some other requester valid.
- If burst_cnt would reach MAX_GRANT_BURST with no other requester valid, burst_cnt saturates at MAX_GRANT_BURST-1 and the grant continues.
- Stall in BURST: no transfer, burst_cnt and grant_idx held, state held (unless valid drops).
- Requesters must keep valid and payload stable until accepted; the arbiter never re-arbitrates away from a valid, un-accepted packet except on burst expiry after a completed transfer.

## Timing
- Accept-to-output latency: 1 cycle (request_out.valid registered from transfer).
- request_out.valid=0 on every non-transfer cycle; payload/id hold last value when invalid.
- Arbitration cost: one IDLE bubble cycle per grant change; first packet after idle appears on request_out 2 cycles after valid rises.
- Steady single requester: 1 packet/cycle indefinitely.
- Two saturated requesters: MAX_GRANT_BURST packets per IDLE bubble, throughput MAX/(MAX+1).
- fifo_stall_in acts combinationally on request_in_ready the same cycle.
- Reset asserted mid-burst: all outputs return to reset values immediately; any accepted-but-unregistered packet is lost (owner of reset responsible).

## Test plan
- Reset: hold ap_rst_n=0 with all requesters valid -> request_in_ready=0, request_out.valid=0, grant_busy=0; first post-reset grant goes to requester 0.
- N=2, MAX=4, both valid continuously with payload counters -> output ids 0,0,0,0,(bubble),1,1,1,1,(bubble),0…; no payload lost or duplicated.
- Only requester 1 valid for 10 packets -> 10 consecutive outputs id=1 after one IDLE cycle, burst_cnt saturates at 3, no bubbles.
- fifo_stall_in high 3 cycles mid-burst of requester 0 -> request_in_ready=0 those cycles, request_out.valid=0 one cycle later for 3 cycles, burst resumes with same grant and count.
- N=4, requesters 1 and 3 valid, last_grant=1 -> grant goes to 3, then back to 1 (0 and 2 skipped).
- Requester 0 drops valid after 2 packets while requester 1 valid -> FSM to IDLE, then grant 1; last_grant=0 confirmed by next rotation.
